imm_packer: RTL and testbench

Immediate encoder and instruction-memory loader: the inverse of the SE immediate extender. It accepts a 32-bit signed immediate, an immediate-format select and a base instruction word, then scatters the immediate into the I/S/B/J bit positions of the base word. The packed word is written sequentially into instruction memory through a one-cycle write port. It sits between the test/boot loader stream and the instruction memory, so the loader can supply immediates in arithmetic form.

---
 rtl/imm_packer.sv | 183 ++++++++++++++++++
 tb/tb_imm_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// Immediate packer: scatters a signed immediate into I/S/B/J fields of a base word and
// streams the result into instruction memory. Optional range checking via IMM_PACKER_RANGE_CHECK_EN.
module imm_packer #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        src,
   input  logic [31:0]       imm,
   input  logic [31:0]       base,
   input  logic              last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              full,
   output logic              err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PACK  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] FMT_I = 2'd0;
   localparam logic [1:0] FMT_S = 2'd1;
   localparam logic [1:0] FMT_B = 2'd2;
   localparam logic [1:0] FMT_J = 2'd3;

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

   logic [1:0]        state_q, state_nx;
   logic [1:0]        src_q, src_nx;
   logic [31:0]       imm_q, imm_nx;
   logic [31:0]       base_q, base_nx;
   logic              last_q, last_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic [31:0]       wdata_q, wdata_nx;
   logic              we_q, we_nx;
   logic              done_q, done_nx;
   logic              full_q, full_nx;
   logic              err_q, err_nx;
   logic              ready_q, ready_nx;
   logic [31:0]       packed_c;
   logic              range_err_c;

   // Scatter the latched immediate over the base word.
   always_comb begin
      packed_c = base_q;
      case (src_q)
         FMT_I: packed_c[31:20] = imm_q[11:0];
         FMT_S: begin
            packed_c[31:25] = imm_q[11:5];
            packed_c[11:7]  = imm_q[4:0];
         end
         FMT_B: begin
            packed_c[31]    = imm_q[12];
            packed_c[30:25] = imm_q[10:5];
            packed_c[11:8]  = imm_q[4:1];
            packed_c[7]     = imm_q[11];
         end
         default: begin
            packed_c[31]    = imm_q[20];
            packed_c[30:21] = imm_q[10:1];
            packed_c[20]    = imm_q[11];
            packed_c[19:12] = imm_q[19:12];
         end
      endcase
   end

`ifdef IMM_PACKER_RANGE_CHECK_EN
   // Upper bits must be a pure sign extension; branch/jump offsets must be even.
   always_comb begin
      range_err_c = 1'b0;
      case (src_q)
         FMT_I, FMT_S: range_err_c = !((&imm_q[31:11]) || !(|imm_q[31:11]));
         FMT_B:        range_err_c = !((&imm_q[31:12]) || !(|imm_q[31:12])) || imm_q[0];
         default:      range_err_c = !((&imm_q[31:20]) || !(|imm_q[31:20])) || imm_q[0];
      endcase
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm_q[31:21];
   assign range_err_c   = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_nx = state_q;
      src_nx   = src_q;
      imm_nx   = imm_q;
      base_nx  = base_q;
      last_nx  = last_q;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      we_nx    = 1'b0;
      done_nx  = 1'b0;
      full_nx  = full_q;
      err_nx   = err_q;
      if (clr) begin
         state_nx = S_IDLE;
         addr_nx  = BASE_A;
         full_nx  = 1'b0;
         err_nx   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && ready_q) begin
                  src_nx   = src;
                  imm_nx   = imm;
                  base_nx  = base;
                  last_nx  = last;
                  state_nx = S_PACK;
               end
            end
            S_PACK: begin
               if (range_err_c) begin
                  err_nx   = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  wdata_nx = packed_c;
                  we_nx    = 1'b1;
                  state_nx = S_WRITE;
               end
            end
            S_WRITE: begin
               addr_nx = addr_q + ADDR_W'(1);
               if (addr_q == {ADDR_W{1'b1}}) full_nx = 1'b1;
               done_nx  = last_q;
               state_nx = last_q ? S_DONE : S_IDLE;
            end
            default: begin
               addr_nx  = BASE_A;
               state_nx = S_IDLE;
            end
         endcase
      end
      ready_nx = (state_nx == S_IDLE) && !full_nx && !err_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= 2'd0;
         imm_q   <= 32'd0;
         base_q  <= 32'd0;
         last_q  <= 1'b0;
         addr_q  <= BASE_A;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_nx;
         src_q   <= src_nx;
         imm_q   <= imm_nx;
         base_q  <= base_nx;
         last_q  <= last_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         we_q    <= we_nx;
         done_q  <= done_nx;
         full_q  <= full_nx;
         err_q   <= err_nx;
         ready_q <= ready_nx;
      end
   end

   assign in_ready  = ready_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign full      = full_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: directed vector table, randomized words against a field-map model,
// error/clear, mid-write reset and full-memory behaviour on a small instance.
module tb_imm_packer;

   localparam int unsigned BASE = 5;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, last;
   logic [1:0]  src;
   logic [31:0] imm, base;
   logic        in_ready, mem_we, done, full, err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;

   logic        clr_s, in_valid_s;
   logic        in_ready_s, mem_we_s, done_s, full_s, err_s;
   logic [1:0]  mem_addr_s;
   logic [31:0] mem_wdata_s;

   imm_packer #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .src(src), .imm(imm), .base(base), .last(last), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .full(full), .err(err));

   imm_packer #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
      .clk(clk), .rst(rst), .clr(clr_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .src(src), .imm(imm), .base(base), .last(last), .mem_we(mem_we_s),
      .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .done(done_s), .full(full_s), .err(err_s));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] base;
      logic        last;
      logic [31:0] exp;
   } vec_t;

   vec_t        vt [9];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] q_data [$];
   logic [7:0]  q_addr [$];
   logic [7:0]  exp_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: each destination bit names the immediate bit it carries, or none.
   function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [31:0] im,
                                            input logic [31:0] b);
      logic [31:0] w;
      int s;
      w = b;
      for (int d = 0; d < 32; d++) begin
         s = -1;
         case (f)
            2'd0: if (d >= 20) s = d - 20;
            2'd1: if (d >= 25) s = d - 20; else if (d >= 7 && d <= 11) s = d - 7;
            2'd2: if (d == 31) s = 12; else if (d >= 25) s = d - 20;
                  else if (d >= 8 && d <= 11) s = d - 7; else if (d == 7) s = 11;
            default: if (d == 31) s = 20; else if (d >= 21) s = d - 20;
                  else if (d == 20) s = 11; else if (d >= 12) s = d;
         endcase
         if (s >= 0) w[d] = im[s];
      end
      return w;
   endfunction

   task automatic expect_write(input logic [31:0] data, input logic l);
      q_addr.push_back(exp_addr);
      q_data.push_back(data);
      exp_addr = l ? 8'(BASE) : exp_addr + 8'd1;
   endtask

   // Advance one cycle and score any write strobe seen on the main instance.
   task automatic tick();
      @(posedge clk);
      #1;
      if (mem_we) begin
         if (q_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we: addr 0x%02h data 0x%08h, no write expected", mem_addr, mem_wdata);
         end else begin
            chk("wr_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
            chk("wr_data", mem_wdata, q_data.pop_front());
         end
      end
   endtask

   task automatic send(input logic [1:0] s, input logic [31:0] im, input logic [31:0] b,
                       input logic l);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk1("ready_timeout", in_ready, 1'b1);
      src = s; imm = im; base = b; last = l; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  f;
      logic [31:0] r, im, b, w;
      logic        l;
      int          nwr;

      vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, 32'hFFF0_0013};
      vt[1] = '{2'd1, 32'h0000_0008, 32'h0000_2023, 1'b0, 32'h0000_2423};
      vt[2] = '{2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 1'b0, 32'hFE00_0EE3};
      vt[3] = '{2'd3, 32'h0000_0008, 32'h0000_006F, 1'b1, 32'h0080_006F};
      vt[4] = '{2'd0, 32'h0000_07FF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF};
      vt[5] = '{2'd1, 32'hFFFF_F800, 32'h0000_0000, 1'b0, 32'h8000_0000};
      vt[6] = '{2'd2, 32'h0000_0FFE, 32'h0000_0000, 1'b0, 32'h7E00_0F80};
      vt[7] = '{2'd3, 32'hFFF0_0000, 32'h0000_0000, 1'b0, 32'h8000_0000};
      vt[8] = '{2'd3, 32'h000F_FFFE, 32'h0000_0000, 1'b1, 32'h7FFF_F000};

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; clr_s = 1'b0; in_valid_s = 1'b0;
      src = 2'd0; imm = 32'd0; base = 32'd0; last = 1'b0;
      exp_addr = 8'(BASE);
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_full", full, 1'b0);
      chk1("rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with cycle-exact handshake timing.
      for (int i = 0; i < 9; i++) begin
         expect_write(vt[i].exp, vt[i].last);
         send(vt[i].src, vt[i].imm, vt[i].base, vt[i].last);
         chk1("pack_ready", in_ready, 1'b0);
         chk1("pack_we", mem_we, 1'b0);
         tick();
         chk1("write_we", mem_we, 1'b1);
         chk1("write_ready", in_ready, 1'b0);
         tick();
         chk1("after_we", mem_we, 1'b0);
         if (vt[i].last) begin
            chk1("done_pulse", done, 1'b1);
            chk1("done_ready", in_ready, 1'b0);
            tick();
            chk1("done_clear", done, 1'b0);
            chk1("idle_ready", in_ready, 1'b1);
            chk("done_addr", 32'(mem_addr), 32'(BASE));
         end else begin
            chk1("no_done", done, 1'b0);
            chk1("idle_ready", in_ready, 1'b1);
         end
      end

      // Randomized in-range words against the field-map model.
      for (int i = 0; i < 40; i++) begin
         f = 2'($urandom_range(0, 3));
         r = $urandom;
         case (f)
            2'd0, 2'd1: im = {{20{r[11]}}, r[11:0]};
            2'd2:       im = {{19{r[12]}}, r[12:1], 1'b0};
            default:    im = {{11{r[20]}}, r[20:1], 1'b0};
         endcase
         b = $urandom;
         l = ($urandom_range(0, 7) == 0);
         expect_write(ref_pack(f, im, b), l);
         send(f, im, b, l);
      end
      repeat (4) tick();

      // Out-of-range I immediate.
`ifdef IMM_PACKER_RANGE_CHECK_EN
      send(2'd0, 32'd2048, 32'h0000_0013, 1'b0);
      tick();
      chk1("err_set", err, 1'b1);
      chk1("err_no_we", mem_we, 1'b0);
      chk1("err_ready", in_ready, 1'b0);
      repeat (3) tick();
      chk1("err_sticky", err, 1'b1);
      chk1("err_ready_held", in_ready, 1'b0);
`else
      expect_write(32'h8000_0013, 1'b0);
      send(2'd0, 32'd2048, 32'h0000_0013, 1'b0);
      tick();
      chk1("nochk_we", mem_we, 1'b1);
      chk1("nochk_err", err, 1'b0);
      tick();
`endif
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_addr = 8'(BASE);
      chk1("clr_err", err, 1'b0);
      chk1("clr_ready", in_ready, 1'b1);
      chk("clr_addr", 32'(mem_addr), 32'(BASE));

      // Reset during the write cycle of the second word.
      expect_write(32'h0020_0013, 1'b0);
      send(2'd0, 32'd2, 32'h0000_0013, 1'b0);
      repeat (2) tick();
      expect_write(32'h0010_0013, 1'b0);
      send(2'd0, 32'd1, 32'h0000_0013, 1'b0);
      tick();
      chk1("pre_rst_we", mem_we, 1'b1);
      rst = 1'b1;
      #1;
      chk1("mid_rst_we", mem_we, 1'b0);
      chk1("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_addr", 32'(mem_addr), 32'(BASE));
      chk("mid_rst_wdata", mem_wdata, 32'd0);
      chk1("mid_rst_done", done, 1'b0);
      chk1("mid_rst_full", full, 1'b0);
      chk1("mid_rst_err", err, 1'b0);
      exp_addr = 8'(BASE);
      @(negedge clk);
      rst = 1'b0;
      expect_write(32'h0030_0013, 1'b0);
      send(2'd0, 32'd3, 32'h0000_0013, 1'b0);
      repeat (3) tick();

      // Small instance: five back-to-back words into a four-word memory.
      src = 2'd0; imm = 32'h10; base = 32'h13; last = 1'b0;
      w = ref_pack(2'd0, 32'h10, 32'h13);
      nwr = 0;
      in_valid_s = 1'b1;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (mem_we_s) begin
            chk("small_addr", 32'(mem_addr_s), 32'(nwr));
            chk("small_data", mem_wdata_s, w);
            nwr++;
         end
      end
      in_valid_s = 1'b0;
      chk("small_writes", 32'(nwr), 32'd4);
      chk1("small_full", full_s, 1'b1);
      chk1("small_ready", in_ready_s, 1'b0);
      chk("small_wrap_addr", 32'(mem_addr_s), 32'd0);
      clr_s = 1'b1;
      tick();
      clr_s = 1'b0;
      chk1("small_clr_full", full_s, 1'b0);
      chk1("small_clr_ready", in_ready_s, 1'b1);
      chk("small_clr_addr", 32'(mem_addr_s), 32'd0);

      chk("pending_writes", 32'(q_data.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
